// File: rtl/timer_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_sequencer : one-shot / periodic down-timer control for an up/down/load
//                   counter. Optional cnt_q cross-check via TIMER_SEQ_FAULT_EN.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module timer_sequencer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         periodic,
  input  logic [N-1:0] period,
  input  logic [N-1:0] cnt_q,
  output logic [1:0]   cnt_control,
  output logic [N-1:0] cnt_d,
  output logic         busy,
  output logic         done,
  output logic         fault
);

  localparam logic [1:0]   CTL_HOLD = 2'b00;
  localparam logic [1:0]   CTL_DOWN = 2'b01;
  localparam logic [1:0]   CTL_LOAD = 2'b11;
  localparam logic [N-1:0] TERM_Q   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state;
  logic [N-1:0] period_lat;
  logic         periodic_lat;
  logic         start_ok;
  logic         mismatch;

  assign start_ok = (state == S_IDLE) && start && (period != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      period_lat   <= '0;
      periodic_lat <= 1'b0;
      cnt_control  <= CTL_HOLD;
      cnt_d        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort (stop or counter disagreement) beats terminal detection.
      if ((state != S_IDLE) && (stop || mismatch)) begin
        state       <= S_IDLE;
        cnt_control <= CTL_HOLD;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt_control <= CTL_HOLD;
            if (start_ok) begin
              period_lat   <= period;
              periodic_lat <= periodic;
              cnt_d        <= period;
              cnt_control  <= CTL_LOAD;
              busy         <= 1'b1;
              state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            cnt_control <= CTL_DOWN;
            state       <= S_RUN;
          end
          S_RUN: begin
            if (!pause && (cnt_q == TERM_Q)) begin
              cnt_control <= CTL_HOLD;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              cnt_control <= pause ? CTL_HOLD : CTL_DOWN;
            end
          end
          S_DONE: begin
            if (periodic_lat) begin
              cnt_d       <= period_lat;
              cnt_control <= CTL_LOAD;
              state       <= S_LOAD;
            end else begin
              cnt_control <= CTL_HOLD;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end
          end
          default: begin
            cnt_control <= CTL_HOLD;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef TIMER_SEQ_FAULT_EN
  logic [N-1:0] shadow;

  // Shadow tracks what the counter should hold given the commands issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      fault  <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        shadow <= period_lat;
      end else if ((state == S_RUN) && (cnt_control == CTL_DOWN)) begin
        shadow <= shadow - 1'b1;
      end
      if (start_ok) begin
        fault <= 1'b0;
      end else if (mismatch && !stop) begin
        fault <= 1'b1;
      end
    end
  end

  assign mismatch = (state == S_RUN) && (cnt_q != shadow);
`else
  assign mismatch = 1'b0;
  assign fault    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// Bench for timer_sequencer: vector table, directed corner sequences and a
// randomized run against a cycle-level behavioural model with its own counter.
module tb_timer_sequencer;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset, start, stop, pause, periodic;
  logic [N-1:0] period;
  logic [N-1:0] cnt_q, ctr_q, force_val;
  logic         force_en;
  logic [1:0]   cnt_control;
  logic [N-1:0] cnt_d;
  logic         busy, done, fault;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit           m_busy, m_load, m_fin, m_done, m_perio;
  logic [1:0]   m_ctl;
  logic [N-1:0] m_cd, m_q, m_per;

  timer_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .period(period), .cnt_q(cnt_q),
    .cnt_control(cnt_control), .cnt_d(cnt_d), .busy(busy), .done(done),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // stand-in for the generic up/down/load counter
  always @(posedge clk) begin
    if (reset) ctr_q <= '0;
    else begin
      case (cnt_control)
        2'b01:   ctr_q <= ctr_q - 1'b1;
        2'b10:   ctr_q <= ctr_q + 1'b1;
        2'b11:   ctr_q <= cnt_d;
        default: ctr_q <= ctr_q;
      endcase
    end
  end
  assign cnt_q = force_en ? force_val : ctr_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, sample at edge+1.
  task automatic step(input bit r, input bit st, input bit sp, input bit pa,
                      input bit pd, input logic [N-1:0] per);
    logic [N-1:0] q_next;
    reset = r; start = st; stop = sp; pause = pa; periodic = pd; period = per;
    q_next = m_q;
    if (m_ctl == 2'b01)      q_next = m_q - 1'b1;
    else if (m_ctl == 2'b11) q_next = m_cd;
    m_done = 1'b0;
    if (r) begin
      m_busy = 0; m_load = 0; m_fin = 0; m_perio = 0;
      m_ctl = 2'b00; m_cd = '0; m_per = '0; q_next = '0;
    end else if (!m_busy) begin
      m_ctl = 2'b00;
      if (st && per != '0) begin
        m_busy = 1; m_load = 1; m_ctl = 2'b11;
        m_cd = per; m_per = per; m_perio = pd;
      end
    end else if (sp) begin
      m_busy = 0; m_load = 0; m_fin = 0; m_ctl = 2'b00;
    end else if (m_load) begin
      m_load = 0; m_ctl = 2'b01;
    end else if (m_fin) begin
      m_fin = 0;
      if (m_perio) begin m_load = 1; m_ctl = 2'b11; m_cd = m_per; end
      else begin m_busy = 0; m_ctl = 2'b00; end
    end else begin
      if (!pa && m_q == 1) begin m_fin = 1; m_done = 1; m_ctl = 2'b00; end
      else m_ctl = pa ? 2'b00 : 2'b01;
    end
    m_q = q_next;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d ctl", cyc), cnt_control, m_ctl);
    chk($sformatf("rnd%0d busy", cyc), busy, m_busy);
    chk($sformatf("rnd%0d done", cyc), done, m_done);
    chk($sformatf("rnd%0d fault", cyc), fault, 1'b0);
    chk($sformatf("rnd%0d cnt_q", cyc), cnt_q, m_q);
    if (m_ctl == 2'b11) chk($sformatf("rnd%0d cnt_d", cyc), cnt_d, m_cd);
  endtask

  typedef struct {
    bit           rst;
    bit           st;
    logic [N-1:0] per;
    logic [1:0]   ctl;
    bit           bsy;
    bit           dn;
    logic [N-1:0] q;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 1; start = 0; stop = 0; pause = 0; periodic = 0; period = '0;
    force_en = 0; force_val = '0;
    m_busy = 0; m_load = 0; m_fin = 0; m_done = 0; m_perio = 0;
    m_ctl = 2'b00; m_cd = '0; m_q = '0; m_per = '0;

    // One-shot P=5; a start while busy (row 3) must be ignored.
    tbl[0] = '{1'b1, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 16'd5, 2'b11, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 16'd0, 2'b01, 1'b1, 1'b0, 16'd5};
    tbl[3] = '{1'b0, 1'b1, 16'd9, 2'b01, 1'b1, 1'b0, 16'd4};
    tbl[4] = '{1'b0, 1'b0, 16'd0, 2'b01, 1'b1, 1'b0, 16'd3};
    tbl[5] = '{1'b0, 1'b0, 16'd0, 2'b01, 1'b1, 1'b0, 16'd2};
    tbl[6] = '{1'b0, 1'b0, 16'd0, 2'b01, 1'b1, 1'b0, 16'd1};
    tbl[7] = '{1'b0, 1'b0, 16'd0, 2'b00, 1'b1, 1'b1, 16'd0};
    tbl[8] = '{1'b0, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].st, 1'b0, 1'b0, 1'b0, tbl[i].per);
      chk($sformatf("tbl%0d ctl", i), cnt_control, tbl[i].ctl);
      chk($sformatf("tbl%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d done", i), done, tbl[i].dn);
      chk($sformatf("tbl%0d cnt_q", i), cnt_q, tbl[i].q);
      if (i == 0) begin
        chk("reset cnt_d", cnt_d, 16'd0);
        chk("reset fault", fault, 1'b0);
      end
      if (i == 1) chk("load cnt_d", cnt_d, 16'd5);
    end

    // Periodic P=3: done every 5 edges, busy never drops.
    step(1, 0, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 1, 16'd3);
    chk("per busy e1", busy, 1'b1);
    for (int e = 2; e <= 20; e++) begin
      step(0, 0, 0, 0, 0, 16'd0);
      chk($sformatf("per done e%0d", e), done, (e % 5 == 0));
      chk($sformatf("per busy e%0d", e), busy, 1'b1);
    end
    step(0, 0, 1, 0, 0, 16'd0);
    chk("per stop busy", busy, 1'b0);

    // P=4 with pause sampled on edges 3..5: done moves to edge 9.
    step(1, 0, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 16'd4);
    for (int e = 2; e <= 10; e++) begin
      step(0, 0, 0, (e >= 3 && e <= 5), 0, 16'd0);
      chk($sformatf("pause done e%0d", e), done, (e == 9));
      if (e >= 3 && e <= 5) chk($sformatf("pause ctl e%0d", e), cnt_control, 2'b00);
      if (e == 6) chk("pause ctl resume", cnt_control, 2'b01);
    end
    chk("pause idle after", busy, 1'b0);

    // stop on the terminal cycle, then start with P=0.
    step(1, 0, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 16'd3);
    for (int e = 2; e <= 4; e++) step(0, 0, 0, 0, 0, 16'd0);
    chk("stop cnt_q at 1", cnt_q, 16'd1);
    step(0, 0, 1, 0, 0, 16'd0);
    chk("stop done", done, 1'b0);
    chk("stop busy", busy, 1'b0);
    chk("stop ctl", cnt_control, 2'b00);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0, 1, 16'd0);
      chk($sformatf("p0 busy %0d", k), busy, 1'b0);
      chk($sformatf("p0 ctl %0d", k), cnt_control, 2'b00);
      chk($sformatf("p0 done %0d", k), done, 1'b0);
    end

    // Synchronous reset in RUN, P=10.
    step(0, 1, 0, 0, 1, 16'd10);
    for (int e = 0; e < 4; e++) step(0, 0, 0, 0, 0, 16'd0);
    chk("pre-reset busy", busy, 1'b1);
    step(1, 1, 0, 1, 1, 16'd10);
    chk("mid reset ctl", cnt_control, 2'b00);
    chk("mid reset busy", busy, 1'b0);
    chk("mid reset done", done, 1'b0);
    chk("mid reset fault", fault, 1'b0);
    chk("mid reset cnt_d", cnt_d, 16'd0);

`ifdef TIMER_SEQ_FAULT_EN
    // Corrupt cnt_q while the counter should hold 3.
    step(0, 1, 0, 0, 0, 16'd5);
    for (int e = 2; e <= 4; e++) step(0, 0, 0, 0, 0, 16'd0);
    force_en = 1; force_val = 16'd7;
    step(0, 0, 0, 0, 0, 16'd0);
    force_en = 0;
    chk("fault set", fault, 1'b1);
    chk("fault busy", busy, 1'b0);
    chk("fault done", done, 1'b0);
    chk("fault ctl", cnt_control, 2'b00);
    step(0, 1, 0, 0, 0, 16'd2);
    chk("fault cleared", fault, 1'b0);
    chk("fault restart busy", busy, 1'b1);
    step(0, 0, 1, 0, 0, 16'd0);
`endif

    // Randomized run against the model.
    step(1, 0, 0, 0, 0, 16'd0);
    for (int c = 0; c < 3000; c++) begin
      int sel;
      logic [N-1:0] per;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      per = '0;
      else if (sel == 1) per = N'($urandom_range(0, 65535));
      else               per = N'($urandom_range(1, 8));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 20,
           $urandom_range(0, 1) == 1, per);
      check_model(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
